// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RMW_RD   = 3'd3,
        ST_RMW_WAIT = 3'd4,
        ST_WR       = 3'd5
    } state_t;

    // Alignment fault for a given size and low address bits; size 11 always faults.
    function automatic logic align_fault(input logic [1:0] size, input logic [1:0] offset);
        logic fault;
        case (size)
            SIZE_BYTE: fault = 1'b0;
            SIZE_HALF: fault = offset[0];
            SIZE_WORD: fault = |offset;
            default:   fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: load extraction/extension and sub-word store merge.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes of the memory word.
    always_comb begin
        byte_s = word[{offset, 3'b000} +: 8];
        if (offset[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Sign- or zero-extend the selected lane to a full load result.
    always_comb begin
        load_data = 32'h0000_0000;
        case (size)
            SIZE_BYTE: load_data = is_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SIZE_HALF: load_data = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            SIZE_WORD: load_data = word;
            default:   load_data = 32'h0000_0000;
        endcase
    end

    // Replace only the target lane of the old word with right-justified store data.
    always_comb begin
        merged_word = word;
        case (size)
            SIZE_BYTE: merged_word[{offset, 3'b000} +: 8] = new_data[7:0];
            SIZE_HALF: begin
                if (offset[1]) begin
                    merged_word[31:16] = new_data[15:0];
                end else begin
                    merged_word[15:0] = new_data[15:0];
                end
            end
            SIZE_WORD: merged_word = new_data;
            default:   merged_word = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-addressed, 1-cycle-read data memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    state_t      state_r;
    logic [1:0]  size_r;
    logic [1:0]  offset_r;
    logic        unsigned_r;
    logic [31:0] wdata_r;
    logic        err_s;
    logic [31:0] load_data_s;
    logic [31:0] merged_s;

    // Request fault: misaligned, illegal size, or beyond the memory's byte range.
    always_comb begin
        err_s = align_fault(req_size, req_addr[1:0]) | (req_addr >= ADDR_LIMIT);
    end

    mem_lane_align u_align (
        .word        (mem_rdata),
        .offset      (offset_r),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .new_data    (wdata_r),
        .load_data   (load_data_s),
        .merged_word (merged_s)
    );

    // Control FSM: latches the request, sequences memory strobes, registers the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            req_ready  <= 1'b1;
            size_r     <= 2'b00;
            offset_r   <= 2'b00;
            unsigned_r <= 1'b0;
            wdata_r    <= 32'h0000_0000;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && err_s) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else if (req_valid) begin
                        size_r     <= req_size;
                        offset_r   <= req_addr[1:0];
                        unsigned_r <= req_unsigned;
                        wdata_r    <= req_wdata;
                        mem_addr   <= {{(32 - IW){1'b0}}, req_addr[IW+1:2]};
                        req_ready  <= 1'b0;
                        if (req_write && (req_size == SIZE_WORD)) begin
                            mem_wdata <= req_wdata;
                            mem_write <= 1'b1;
                            state_r   <= ST_WR;
                        end else if (req_write) begin
                            mem_read <= 1'b1;
                            state_r  <= ST_RMW_RD;
                        end else begin
                            mem_read <= 1'b1;
                            state_r  <= ST_RD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD:       state_r <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    resp_rdata <= load_data_s;
                    resp_valid <= 1'b1;
                    req_ready  <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                ST_RMW_RD:   state_r <= ST_RMW_WAIT;
                ST_RMW_WAIT: begin
                    mem_wdata <= merged_s;
                    mem_write <= 1'b1;
                    state_r   <= ST_WR;
                end
                ST_WR: begin
                    resp_valid <= 1'b1;
                    req_ready  <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural 1-cycle memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [1024];
    int vectors = 0;
    int miscompares = 0;
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, resp_cnt = 0;

    mem_access_unit #(.DEPTH(1024), .IW(10)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, write on posedge.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[9:0]];
    end

    // Strobe and response activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (mem_read && mem_write) both_cnt++;
        if (resp_valid) resp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for accept, return latency (99 on timeout) and response.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er);
        int bound;
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        bound = 0;
        while (!req_ready && bound < 50) begin
            @(posedge clk); #1; bound++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!resp_valid) lat = 99;
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk); #1;
    endtask

    int lat, r0, w0, acc_n, resp_n, busy_ready, c0;
    logic [31:0] rd;
    logic er, adv;
    logic [31:0] q_addr [3];
    logic [31:0] q_exp [3];
    logic [31:0] got [3];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
        mem[3] = 32'h8844_22F0;
        mem[5] = 32'h0123_4567;
        mem[8] = 32'hAAAA_AAAA;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_ready", {31'h0, req_ready}, 32'h1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Sub-word loads with sign and zero extension.
        r0 = rd_cnt; w0 = wr_cnt;
        run_req(1'b0, 2'b00, 1'b0, 32'h0C, 32'h0, lat, rd, er);
        check("lb_data", rd, 32'hFFFF_FFF0);
        check("lb_lat", lat, 32'd3);
        check("lb_err", {31'h0, er}, 32'h0);
        run_req(1'b0, 2'b00, 1'b1, 32'h0C, 32'h0, lat, rd, er);
        check("lbu_data", rd, 32'h0000_00F0);
        check("lbu_lat", lat, 32'd3);
        run_req(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, lat, rd, er);
        check("lh_data", rd, 32'hFFFF_8844);
        check("lh_lat", lat, 32'd3);
        check("load_reads", rd_cnt - r0, 32'd3);
        check("load_writes", wr_cnt - w0, 32'd0);

        // Word store then byte read-modify-write store.
        w0 = wr_cnt;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        check("sw_lat", lat, 32'd2);
        check("sw_rdata", rd, 32'h0);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        r0 = rd_cnt; w0 = wr_cnt;
        run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_005A, lat, rd, er);
        check("sb_lat", lat, 32'd4);
        check("sb_err", {31'h0, er}, 32'h0);
        check("sb_mem", mem[4], 32'hDEAD_5AEF);
        check("sb_writes", wr_cnt - w0, 32'd1);
        check("sb_reads", rd_cnt - r0, 32'd1);

        // Error cases: no memory access, latency 1.
        r0 = rd_cnt; w0 = wr_cnt;
        run_req(1'b0, 2'b01, 1'b0, 32'h01, 32'h0, lat, rd, er);
        check("lh_mis_err", {31'h0, er}, 32'h1);
        check("lh_mis_lat", lat, 32'd1);
        run_req(1'b1, 2'b10, 1'b0, 32'h06, 32'h1111_1111, lat, rd, er);
        check("sw_mis_err", {31'h0, er}, 32'h1);
        check("sw_mis_lat", lat, 32'd1);
        run_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, lat, rd, er);
        check("size11_err", {31'h0, er}, 32'h1);
        check("size11_lat", lat, 32'd1);
        run_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, rd, er);
        check("range_err", {31'h0, er}, 32'h1);
        check("range_lat", lat, 32'd1);
        check("range_rdata", rd, 32'h0);
        check("err_strobes", (rd_cnt - r0) + (wr_cnt - w0), 32'd0);

        // Back-to-back loads with req_valid held high.
        q_addr[0] = 32'h0C; q_addr[1] = 32'h10; q_addr[2] = 32'h14;
        q_exp[0] = 32'h8844_22F0; q_exp[1] = 32'hDEAD_5AEF; q_exp[2] = 32'h0123_4567;
        for (int i = 0; i < 3; i++) got[i] = 32'h0;
        acc_n = 0; resp_n = 0; busy_ready = 0; r0 = rd_cnt;
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = q_addr[0]; req_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && resp_n < 3; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (resp_n < 3) got[resp_n] = resp_rdata;
                resp_n++;
            end
            if (acc_n > resp_n && req_ready) busy_ready++;
            adv = 1'b0;
            if (req_valid && req_ready) begin
                acc_n++;
                adv = 1'b1;
            end
            @(posedge clk); #1;
            if (adv) begin
                if (acc_n < 3) req_addr = q_addr[acc_n];
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc_n, 32'd3);
        check("b2b_resps", resp_n, 32'd3);
        check("b2b_busy_ready", busy_ready, 32'd0);
        check("b2b_data0", got[0], q_exp[0]);
        check("b2b_data1", got[1], q_exp[1]);
        check("b2b_data2", got[2], q_exp[2]);
        check("b2b_reads", rd_cnt - r0, 32'd3);
        @(posedge clk); #1;

        // Reset during RMW_WAIT drops the store.
        w0 = wr_cnt; c0 = resp_cnt;
        req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h22; req_wdata = 32'h0000_1234; req_valid = 1'b1;
        @(posedge clk); #1;          // accepted: now in RMW_RD
        req_valid = 1'b0;
        check("rmw_rd_strobe", {31'h0, mem_read}, 32'h1);
        @(posedge clk); #1;          // now in RMW_WAIT
        reset = 1'b1;
        #1;
        check("rst_mid_write", {31'h0, mem_write}, 32'h0);
        check("rst_mid_resp", {31'h0, resp_valid}, 32'h0);
        check("rst_mid_wdata", mem_wdata, 32'h0);
        check("rst_mid_addr", mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_mem", mem[8], 32'hAAAA_AAAA);
        check("rst_mid_writes", wr_cnt - w0, 32'd0);
        check("rst_mid_noresp", resp_cnt - c0, 32'd0);
        check("never_both", both_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
